reg_file32: RTL and testbench

Thirty-two-entry, 32-bit general-purpose register file for the single-cycle CPU datapath.
- Sits directly downstream of the 5-to-32 enabled write decoder (DEC5T32E), whose one-hot output gates the write of each register.
- Provides two asynchronous read ports for the rs/rt operands and one synchronous write port for the rd/rt writeback.
- Register 0 is hardwired to zero.

---
 rtl/reg_file32_pkg.sv | 12 +
 rtl/DEC5T32E.sv | 14 +
 rtl/reg_file32.sv | 71 +++++++
 tb/tb_reg_file32.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file32_pkg.sv
// Shared CPU constants for the register file.
// Address width, register count, default data width, zero register.
package reg_file32_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam int DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/DEC5T32E.sv
// 5-to-32 enabled one-hot decoder.
// Ports: I (5b select), En (enable), D (32b one-hot, all zero when En=0).
module DEC5T32E (
  input  logic [4:0]  I,
  input  logic        En,
  output logic [31:0] D
);

  always_comb begin
    D = '0;
    if (En) D[I] = 1'b1;
  end

endmodule

// File: rtl/reg_file32.sv
// 32 x DATA_W register file, r0 hardwired to zero, 2 async reads + debug read.
// Ports: clk, rst (sync high), ra1/ra2 -> rd1/rd2, wa/wd/we write, dbg_a -> dbg_d.
module reg_file32 #(
  parameter int DATA_W = reg_file32_pkg::DATA_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              we,
  input  logic [4:0]        dbg_a,
  output logic [DATA_W-1:0] dbg_d
);

  import reg_file32_pkg::*;

  logic [NUM_REGS-1:0] wr_en;
  logic [DATA_W-1:0]   regs [1:NUM_REGS-1];
  logic [DATA_W-1:0]   rf_view [NUM_REGS];
  logic                wr_hit;
  logic                unused_en0;

  DEC5T32E u_dec (
    .I  (wa),
    .En (we & ~rst),
    .D  (wr_en)
  );

  // r0 has no storage, so its enable goes nowhere.
  assign unused_en0 = wr_en[ZERO_REG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++)
        if (wr_en[i]) regs[i] <= wd;
    end
  end

  always_comb begin
    rf_view[0] = '0;
    for (int i = 1; i < NUM_REGS; i++)
      rf_view[i] = regs[i];
  end

  // A write that will actually land this edge.
  assign wr_hit = we & ~rst & (wa != ZERO_REG);

  function automatic logic [DATA_W-1:0] rd_port(
    input logic [4:0] a,
    input logic       byp_ok
  );
    if (BYPASS && byp_ok && wr_hit && (a == wa))
      return wd;
    return rf_view[a];
  endfunction

  always_comb begin
    rd1   = rd_port(ra1, 1'b1);
    rd2   = rd_port(ra2, 1'b1);
    dbg_d = rd_port(dbg_a, 1'b0);
  end

endmodule

// File: tb/tb_reg_file32.sv
// Self-checking bench for reg_file32, bypass and non-bypass builds in parallel.
// Directed scenarios plus randomized traffic against an array model.
module tb_reg_file32;

  logic        clk = 1'b0;
  logic        rst, we;
  logic [4:0]  ra1, ra2, wa, dbg_a;
  logic [31:0] wd;
  logic [31:0] rd1_b, rd2_b, dbg_b;
  logic [31:0] rd1_n, rd2_n, dbg_n;
  logic [31:0] model [32];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  reg_file32 #(.DATA_W(32), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_b), .rd2(rd2_b), .wa(wa), .wd(wd),
    .we(we), .dbg_a(dbg_a), .dbg_d(dbg_b)
  );

  reg_file32 #(.DATA_W(32), .BYPASS(1'b0)) u_nob (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_n), .rd2(rd2_n), .wa(wa), .wd(wd),
    .we(we), .dbg_a(dbg_a), .dbg_d(dbg_n)
  );

  // Expected read value from the architectural rules.
  function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
    if (byp && we && !rst && wa != 0 && a == wa) return wd;
    if (a == 0) return 32'h0;
    return model[a];
  endfunction

  // Clock edge plus architectural state update.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we && wa != 0) begin
      model[wa] = wd;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; we = 0; wa = 0; wd = 0;
    ra1 = 0; ra2 = 0; dbg_a = 0;
    tick();
    rst = 0; we = 1; wa = 5; wd = 32'hDEAD_BEEF;
    tick();
    we = 0; ra1 = 5;
    #4;
    n_chk++;
    if (rd1_n !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL pre_reset_r5 got=%h exp=%h", rd1_n, 32'hDEAD_BEEF);
    end
    rst = 1;
    tick();
    rst = 0; ra1 = 5; ra2 = 31; dbg_a = 5;
    #4;
    n_chk++;
    if ({rd1_b, rd2_b, dbg_b} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_byp got=%h %h %h exp=0", rd1_b, rd2_b, dbg_b);
    end
    n_chk++;
    if ({rd1_n, rd2_n, dbg_n} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_nob got=%h %h %h exp=0", rd1_n, rd2_n, dbg_n);
    end
  endtask

  task automatic test_write_read();
    we = 1; wa = 7; wd = 32'h1234_5678; ra1 = 7;
    #4;
    n_chk++;
    if (rd1_b !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL wr_same_cycle_byp got=%h exp=%h", rd1_b, 32'h1234_5678);
    end
    n_chk++;
    if (rd1_n !== 32'h0) begin
      n_fail++;
      $display("FAIL wr_same_cycle_nob got=%h exp=0", rd1_n);
    end
    tick();
    we = 0; ra1 = 7; ra2 = 6; dbg_a = 8;
    #4;
    n_chk++;
    if (rd1_b !== 32'h1234_5678 || rd1_n !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL wr_next_cycle got=%h %h exp=%h",
               rd1_b, rd1_n, 32'h1234_5678);
    end
    n_chk++;
    if (rd2_b !== 32'h0 || dbg_b !== 32'h0 || dbg_n !== 32'h0) begin
      n_fail++;
      $display("FAIL wr_neighbours got=%h %h %h exp=0", rd2_b, dbg_b, dbg_n);
    end
  endtask

  task automatic test_r0();
    we = 1; wa = 0; wd = 32'hFFFF_FFFF;
    ra1 = 0; ra2 = 0; dbg_a = 0;
    #4;
    n_chk++;
    if (rd1_b !== 32'h0 || rd2_b !== 32'h0 || rd1_n !== 32'h0) begin
      n_fail++;
      $display("FAIL r0_no_bypass got=%h %h %h exp=0", rd1_b, rd2_b, rd1_n);
    end
    tick();
    we = 0;
    #4;
    n_chk++;
    if (rd1_b !== 32'h0 || dbg_b !== 32'h0 || dbg_n !== 32'h0) begin
      n_fail++;
      $display("FAIL r0_after_edge got=%h %h %h exp=0", rd1_b, dbg_b, dbg_n);
    end
  endtask

  task automatic test_bypass();
    we = 1; wa = 3; wd = 32'hAAAA_AAAA;
    tick();
    wd = 32'h5555_5555; ra1 = 3; ra2 = 3; dbg_a = 3;
    #4;
    n_chk++;
    if (rd1_b !== 32'h5555_5555 || rd2_b !== 32'h5555_5555) begin
      n_fail++;
      $display("FAIL bypass_on got=%h %h exp=%h", rd1_b, rd2_b, 32'h5555_5555);
    end
    n_chk++;
    if (rd1_n !== 32'hAAAA_AAAA || rd2_n !== 32'hAAAA_AAAA) begin
      n_fail++;
      $display("FAIL bypass_off got=%h %h exp=%h", rd1_n, rd2_n, 32'hAAAA_AAAA);
    end
    n_chk++;
    if (dbg_b !== 32'hAAAA_AAAA || dbg_n !== 32'hAAAA_AAAA) begin
      n_fail++;
      $display("FAIL dbg_not_bypassed got=%h %h exp=%h",
               dbg_b, dbg_n, 32'hAAAA_AAAA);
    end
    tick();
    we = 0;
    #4;
    n_chk++;
    if (rd1_n !== 32'h5555_5555 || rd2_n !== 32'h5555_5555 ||
        dbg_b !== 32'h5555_5555) begin
      n_fail++;
      $display("FAIL bypass_after_edge got=%h %h %h exp=%h",
               rd1_n, rd2_n, dbg_b, 32'h5555_5555);
    end
  endtask

  task automatic test_collision();
    we = 1; wa = 9; wd = 32'h0000_0077;
    tick();
    rst = 1; we = 1; wa = 9; wd = 32'h0000_0042; ra1 = 9; ra2 = 9;
    #4;
    n_chk++;
    if (rd1_b !== 32'h77 || rd2_n !== 32'h77) begin
      n_fail++;
      $display("FAIL rst_no_bypass got=%h %h exp=%h", rd1_b, rd2_n, 32'h77);
    end
    tick();
    rst = 0; we = 0;
    #4;
    n_chk++;
    if (rd1_b !== 32'h0 || rd1_n !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_beats_write got=%h %h exp=0", rd1_b, rd1_n);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] e;
    for (int i = 1; i < 32; i++) begin
      we = 1; wa = 5'(i); wd = i * 32'h0101_0101;
      tick();
    end
    we = 0;
    for (int i = 1; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(i); dbg_a = 5'(i);
      e = i * 32'h0101_0101;
      #2;
      n_chk++;
      if (rd1_b !== e || rd2_b !== e || rd1_n !== e ||
          rd2_n !== e || dbg_b !== e) begin
        n_fail++;
        $display("FAIL sweep r%0d got=%h %h %h %h %h exp=%h",
                 i, rd1_b, rd2_b, rd1_n, rd2_n, dbg_b, e);
      end
    end
  endtask

  task automatic test_random();
    tick();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 15) == 0);
      we = $urandom_range(0, 1);
      wa = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      wd = $urandom;
      ra1 = 5'($urandom);
      ra2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      dbg_a = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      if ($urandom_range(0, 2) == 0) ra1 = wa;
      #4;
      n_chk++;
      if (rd1_b !== exp_rd(1, ra1) || rd2_b !== exp_rd(1, ra2) ||
          dbg_b !== exp_rd(0, dbg_a)) begin
        n_fail++;
        $display("FAIL rand_byp n=%0d got=%h %h %h exp=%h %h %h", n,
                 rd1_b, rd2_b, dbg_b,
                 exp_rd(1, ra1), exp_rd(1, ra2), exp_rd(0, dbg_a));
      end
      n_chk++;
      if (rd1_n !== exp_rd(0, ra1) || rd2_n !== exp_rd(0, ra2) ||
          dbg_n !== exp_rd(0, dbg_a)) begin
        n_fail++;
        $display("FAIL rand_nob n=%0d got=%h %h %h exp=%h %h %h", n,
                 rd1_n, rd2_n, dbg_n,
                 exp_rd(0, ra1), exp_rd(0, ra2), exp_rd(0, dbg_a));
      end
      tick();
    end
    rst = 0; we = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    test_reset();
    test_write_read();
    test_r0();
    test_bypass();
    test_collision();
    test_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
